// File: rtl/knn_topk_vote.sv
// Streaming K-nearest-neighbour back end: keeps the K smallest distances per query,
// votes them into a saturating per-class histogram and arg-max scans it on frame end.
module knn_topk_vote #(
  parameter int unsigned DIST_W    = 14,
  parameter int unsigned CLASS_NUM = 5,
  parameter int unsigned CLASS_W   = 3,
  parameter int unsigned K         = 3,
  parameter int unsigned CNT_W     = 6
) (
  input  logic               clk_en,
  input  logic               reset_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DIST_W-1:0]  s_dist,
  input  logic [CLASS_W-1:0] s_class,
  input  logic               s_last,
  input  logic               frame_end,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CLASS_W-1:0] res_class,
  output logic [CNT_W-1:0]   res_count
);

  localparam int unsigned PosW = $clog2(K + 1);
  localparam int unsigned IdxW = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1;
  localparam int unsigned SumW = CNT_W + PosW;
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(CLASS_NUM - 1);

  typedef enum logic [1:0] {StAccum, StScan, StDone} state_e;

  state_e state_q, state_d;

  logic [DIST_W-1:0]  lst_dist_q [K];
  logic [DIST_W-1:0]  lst_dist_d [K];
  logic [CLASS_W-1:0] lst_cls_q  [K];
  logic [CLASS_W-1:0] lst_cls_d  [K];
  logic [K-1:0]       lst_vld_q, lst_vld_d;

  logic [CLASS_W-1:0] vote_cls_q [K];
  logic [CLASS_W-1:0] vote_cls_d [K];
  logic [K-1:0]       vote_vld_q, vote_vld_d;
  logic               vote_pend_q, vote_pend_d;
  logic               scan_req_q, scan_req_d;

  logic [CNT_W-1:0]   hist_q [CLASS_NUM];
  logic [CNT_W-1:0]   hist_d [CLASS_NUM];
  logic [PosW-1:0]    vote_cnt [CLASS_NUM];
  logic [SumW-1:0]    hist_sum [CLASS_NUM];

  logic [IdxW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]   max_cnt_q, max_cnt_d;
  logic [CLASS_W-1:0] max_cls_q, max_cls_d;

  logic [PosW-1:0]    ins_pos;
  logic [DIST_W-1:0]  shf_dist [K];
  logic [CLASS_W-1:0] shf_cls  [K];
  logic [K-1:0]       shf_vld;
  logic [DIST_W-1:0]  mrg_dist [K];
  logic [CLASS_W-1:0] mrg_cls  [K];
  logic [K-1:0]       mrg_vld;

  logic beat, last_beat, fe_take;

  assign beat      = s_valid & s_ready;
  assign last_beat = beat & s_last;
  // frame_end is only honoured in ACCUM and only once while a scan request waits
  assign fe_take   = (state_q == StAccum) & frame_end & ~scan_req_q;

  // Insertion slot = number of valid entries with dist <= s_dist; equal distances stay ahead.
  always_comb begin
    ins_pos = '0;
    for (int k = 0; k < K; k++) begin
      if (lst_vld_q[k] && (lst_dist_q[k] <= s_dist)) begin
        ins_pos = ins_pos + PosW'(1);
      end
    end
    shf_dist[0] = '0;
    shf_cls[0]  = '0;
    shf_vld[0]  = 1'b0;
    for (int k = 1; k < K; k++) begin
      shf_dist[k] = lst_dist_q[k-1];
      shf_cls[k]  = lst_cls_q[k-1];
      shf_vld[k]  = lst_vld_q[k-1];
    end
    for (int k = 0; k < K; k++) begin
      if (PosW'(k) < ins_pos) begin
        mrg_dist[k] = lst_dist_q[k];
        mrg_cls[k]  = lst_cls_q[k];
        mrg_vld[k]  = lst_vld_q[k];
      end else if (PosW'(k) == ins_pos) begin
        mrg_dist[k] = s_dist;
        mrg_cls[k]  = s_class;
        mrg_vld[k]  = 1'b1;
      end else begin
        mrg_dist[k] = shf_dist[k];
        mrg_cls[k]  = shf_cls[k];
        mrg_vld[k]  = shf_vld[k];
      end
    end
  end

  // List and vote snapshot; the list clears on query end so the next beat needs no bubble.
  always_comb begin
    lst_dist_d  = lst_dist_q;
    lst_cls_d   = lst_cls_q;
    lst_vld_d   = lst_vld_q;
    vote_cls_d  = vote_cls_q;
    vote_vld_d  = vote_vld_q;
    vote_pend_d = last_beat;
    if (last_beat) begin
      vote_cls_d = mrg_cls;
      vote_vld_d = mrg_vld;
    end
    if (last_beat || fe_take) begin
      lst_vld_d = '0;
    end else if (beat) begin
      lst_dist_d = mrg_dist;
      lst_cls_d  = mrg_cls;
      lst_vld_d  = mrg_vld;
    end
  end

  always_comb begin
    for (int c = 0; c < CLASS_NUM; c++) begin
      vote_cnt[c] = '0;
      for (int k = 0; k < K; k++) begin
        if (vote_vld_q[k] && (vote_cls_q[k] == CLASS_W'(c))) begin
          vote_cnt[c] = vote_cnt[c] + PosW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CLASS_NUM; c++) begin
      hist_sum[c] = SumW'(hist_q[c]) + SumW'(vote_cnt[c]);
      hist_d[c]   = hist_q[c];
      if ((state_q == StDone) && res_ready) begin
        hist_d[c] = '0;
      end else if (vote_pend_q) begin
        hist_d[c] = (hist_sum[c] > SumW'(CntMax)) ? CntMax : hist_sum[c][CNT_W-1:0];
      end
    end
  end

  // Arg-max scan; strict > keeps the lowest class index on ties.
  always_comb begin
    idx_d     = idx_q;
    max_cnt_d = max_cnt_q;
    max_cls_d = max_cls_q;
    if (state_q == StScan) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
      if ((idx_q == '0) || (hist_q[idx_q] > max_cnt_q)) begin
        max_cnt_d = hist_q[idx_q];
        max_cls_d = CLASS_W'(idx_q);
      end
    end
  end

  // Next-state logic; the scan waits until any vote in flight has reached the histogram.
  always_comb begin
    state_d    = state_q;
    scan_req_d = scan_req_q;
    unique case (state_q)
      StAccum: begin
        if (fe_take || scan_req_q) begin
          if (vote_pend_d) begin
            scan_req_d = 1'b1;
          end else begin
            scan_req_d = 1'b0;
            state_d    = StScan;
          end
        end
      end
      StScan: begin
        if (idx_q == IdxLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_comb begin
    s_ready   = (state_q == StAccum) & ~scan_req_q;
    res_valid = (state_q == StDone);
    busy      = (state_q != StAccum) | vote_pend_q | scan_req_q;
    res_class = max_cls_q;
    res_count = max_cnt_q;
  end

  always_ff @(posedge clk_en) begin
    if (!reset_n) begin
      state_q     <= StAccum;
      lst_dist_q  <= '{default: '0};
      lst_cls_q   <= '{default: '0};
      lst_vld_q   <= '0;
      vote_cls_q  <= '{default: '0};
      vote_vld_q  <= '0;
      vote_pend_q <= 1'b0;
      scan_req_q  <= 1'b0;
      hist_q      <= '{default: '0};
      idx_q       <= '0;
      max_cnt_q   <= '0;
      max_cls_q   <= '0;
    end else begin
      state_q     <= state_d;
      lst_dist_q  <= lst_dist_d;
      lst_cls_q   <= lst_cls_d;
      lst_vld_q   <= lst_vld_d;
      vote_cls_q  <= vote_cls_d;
      vote_vld_q  <= vote_vld_d;
      vote_pend_q <= vote_pend_d;
      scan_req_q  <= scan_req_d;
      hist_q      <= hist_d;
      idx_q       <= idx_d;
      max_cnt_q   <= max_cnt_d;
      max_cls_q   <= max_cls_d;
    end
  end

endmodule

// File: tb/tb_knn_topk_vote.sv
// Directed bench for knn_topk_vote: a scoreboard queue holds hand-computed results and a
// monitor pops and compares on every result handshake.
module tb_knn_topk_vote;

  logic        clk_en = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [13:0] s_dist = '0;
  logic [2:0]  s_class = '0;
  logic        s_last = 1'b0;
  logic        frame_end = 1'b0;
  logic        busy;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [2:0]  res_class;
  logic [5:0]  res_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cls_q[$];
  int exp_cnt_q[$];

  knn_topk_vote dut (
    .clk_en    (clk_en),
    .reset_n   (reset_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_dist    (s_dist),
    .s_class   (s_class),
    .s_last    (s_last),
    .frame_end (frame_end),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_class (res_class),
    .res_count (res_count)
  );

  always #5 clk_en = ~clk_en;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk_en) begin
    if (reset_n && res_valid && res_ready) begin
      if (exp_cls_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        check("res_class", int'(res_class), exp_cls_q.pop_front());
        check("res_count", int'(res_count), exp_cnt_q.pop_front());
      end
    end
  end

  task automatic expect_res(input int c, input int n);
    exp_cls_q.push_back(c);
    exp_cnt_q.push_back(n);
  endtask

  task automatic beat(input int d, input int c, input bit last, input bit fe);
    s_valid   = 1'b1;
    s_dist    = 14'(d);
    s_class   = 3'(c);
    s_last    = last;
    frame_end = fe;
    @(posedge clk_en);
    #1;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_en);
    #1;
  endtask

  task automatic issue_fe();
    frame_end = 1'b1;
    @(posedge clk_en);
    #1;
    frame_end = 1'b0;
  endtask

  // Counts negedges after the frame_end edge until res_valid; lat_exp=0 only checks arrival.
  task automatic wait_result(input string name, input int lat_exp);
    int cyc = 0;
    while (!res_valid && cyc < 60) begin
      @(negedge clk_en);
      cyc++;
    end
    if (lat_exp > 0) check(name, cyc, lat_exp);
    else check(name, int'(res_valid), 1);
  endtask

  task automatic handshake();
    @(posedge clk_en);
    #1;
    res_ready = 1'b1;
    @(posedge clk_en);
    #1;
    res_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk_en);
    #1;
    reset_n = 1'b1;
    @(negedge clk_en);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_class", int'(res_class), 0);
    check("rst_res_count", int'(res_count), 0);
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_busy", int'(busy), 0);
    idle(1);

    // Ties keep the earlier sample lower; 20 is discarded -> votes c1,c3,c2 -> class 1.
    expect_res(1, 1);
    beat(10, 0, 0, 0); beat(4, 1, 0, 0); beat(7, 2, 0, 0); beat(4, 3, 0, 0); beat(20, 4, 1, 0);
    issue_fe();
    wait_result("default_arrive", 0);
    handshake();

    // Short query casts only its two entries.
    expect_res(2, 2);
    beat(5, 2, 0, 0); beat(9, 2, 1, 0);
    issue_fe();
    wait_result("short_arrive", 0);
    handshake();

    // Equal to the max of a full list is discarded -> three c0 votes.
    expect_res(0, 3);
    beat(5, 0, 0, 0); beat(6, 0, 0, 0); beat(7, 0, 0, 0); beat(7, 1, 1, 0);
    issue_fe();
    wait_result("eqmax_arrive", 0);
    handshake();

    // Labels 7 and 6 are out of range and ignored; idle first so latency is the base case.
    expect_res(3, 1);
    beat(1, 7, 0, 0); beat(2, 6, 0, 0); beat(9, 3, 1, 0);
    idle(2);
    issue_fe();
    wait_result("lat_idle", 6);
    handshake();

    // Back-to-back queries: c2 gets 1+2, c1 gets 2, c0 gets 1.
    expect_res(2, 3);
    beat(1, 2, 1, 0);
    beat(1, 1, 0, 0); beat(2, 1, 1, 0);
    beat(8, 2, 0, 0); beat(9, 2, 0, 0); beat(3, 2, 0, 0); beat(4, 0, 1, 0);
    issue_fe();
    wait_result("b2b_arrive", 0);
    handshake();

    // frame_end together with s_last: vote counted, one extra cycle of latency.
    expect_res(0, 1);
    beat(3, 0, 1, 1);
    wait_result("lat_fe_with_last", 7);
    handshake();

    // 70 queries x 3 class-4 votes saturate at 63.
    expect_res(4, 63);
    for (int q = 0; q < 70; q++) begin
      beat(5, 0, 0, 0); beat(1, 4, 0, 0); beat(2, 4, 0, 0); beat(3, 4, 1, 0);
    end
    issue_fe();
    wait_result("sat_arrive", 0);
    handshake();

    // Backpressure: result held, input stalled, offered beats must not be counted.
    expect_res(3, 1);
    beat(1, 3, 1, 0);
    idle(1);
    issue_fe();
    wait_result("bp_arrive", 0);
    s_valid = 1'b1; s_dist = 14'd2; s_class = 3'd4; s_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_en);
      check("bp_res_valid_held", int'(res_valid), 1);
      check("bp_s_ready_low", int'(s_ready), 0);
    end
    check("bp_class_held", int'(res_class), 3);
    check("bp_count_held", int'(res_count), 1);
    s_valid = 1'b0; s_last = 1'b0;
    handshake();
    expect_res(0, 0);
    issue_fe();
    wait_result("lat_empty", 6);
    handshake();

    // Reset mid-scan drops the frame and clears the histogram.
    beat(3, 1, 1, 0);
    issue_fe();
    idle(2);
    reset_n = 1'b0;
    @(posedge clk_en);
    #1;
    reset_n = 1'b1;
    @(negedge clk_en);
    check("midrst_res_valid", int'(res_valid), 0);
    check("midrst_s_ready", int'(s_ready), 1);
    check("midrst_busy", int'(busy), 0);
    idle(1);
    expect_res(0, 0);
    issue_fe();
    wait_result("midrst_arrive", 6);
    handshake();

    idle(3);
    check("scoreboard_empty", exp_cls_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
